// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle control unit for the 8-bit accumulator datapath: FETCH/EXEC/UPDATE sequencing
// with programmable memory wait states, zero-flag jumps, halt, run/pause and a retired-instruction count.
module unidade_controle_multiciclo #(
   parameter int MEM_WAIT = 0,
   parameter int CNT_W    = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run,
   input  logic [3:0]       opcode,
   input  logic [7:0]       acc,
   output logic             dp_reset,
   output logic             ld_ac,
   output logic             ac_src,
   output logic             ld_pc,
   output logic             pc_src,
   output logic             dm_we,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count,
   output logic [2:0]       dbgState
);

   typedef enum logic [2:0] {
      INIT   = 3'd0,
      FETCH  = 3'd1,
      EXEC   = 3'd2,
      UPDATE = 3'd3,
      HALT   = 3'd4
   } state_t;

   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_STA = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h7;
   localparam logic [3:0] OP_JMP = 4'h9;
   localparam logic [3:0] OP_JZ  = 4'hA;
   localparam logic [3:0] OP_JNZ = 4'hB;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT);
   localparam logic [3:0] WAIT_PRE = WAIT_MAX - 4'd1;

   state_t     state;
   logic [3:0] waitCnt;
   logic [3:0] irOp;

   assign dbgState = state;

   function automatic logic isMemRead(input logic [3:0] op);
      return (op == OP_LDA) || ((op >= OP_ADD) && (op <= OP_XOR));
   endfunction

   // {ld_ac, ac_src, dm_we} for the final EXEC cycle of an opcode.
   function automatic logic [2:0] execStrobes(input logic [3:0] op);
      if (op == OP_LDA)                        return 3'b110;
      else if ((op >= OP_ADD) && (op <= OP_XOR)) return 3'b100;
      else if (op == OP_STA)                   return 3'b001;
      else                                     return 3'b000;
   endfunction

   function automatic logic takeJump(input logic [3:0] op, input logic [7:0] a);
      if (op == OP_JMP)      return 1'b1;
      else if (op == OP_JZ)  return (a == 8'h00);
      else if (op == OP_JNZ) return (a != 8'h00);
      else                   return 1'b0;
   endfunction

   // Outputs are registered: each transition loads the output values of the state being entered.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= INIT;
         waitCnt     <= 4'd0;
         irOp        <= 4'd0;
         instr_count <= '0;
         dp_reset    <= 1'b1;
         ld_ac       <= 1'b0;
         ac_src      <= 1'b0;
         ld_pc       <= 1'b0;
         pc_src      <= 1'b0;
         dm_we       <= 1'b0;
         halted      <= 1'b0;
      end else begin
         dp_reset <= 1'b0;
         ld_ac    <= 1'b0;
         ac_src   <= 1'b0;
         ld_pc    <= 1'b0;
         pc_src   <= 1'b0;
         dm_we    <= 1'b0;
         halted   <= 1'b0;
         case (state)
            INIT: state <= FETCH;
            FETCH: begin
               if (run) begin
                  if (waitCnt == WAIT_MAX) begin
                     irOp    <= opcode;
                     waitCnt <= 4'd0;
                     state   <= EXEC;
                     // Single-cycle EXEC: its strobes must be present on entry.
                     if (!isMemRead(opcode) || (WAIT_MAX == 4'd0))
                        {ld_ac, ac_src, dm_we} <= execStrobes(opcode);
                  end else begin
                     waitCnt <= waitCnt + 4'd1;
                  end
               end
            end
            EXEC: begin
               if (isMemRead(irOp) && (waitCnt != WAIT_MAX)) begin
                  waitCnt <= waitCnt + 4'd1;
                  if (waitCnt == WAIT_PRE)
                     {ld_ac, ac_src, dm_we} <= execStrobes(irOp);
               end else begin
                  waitCnt <= 4'd0;
                  if (irOp == OP_HLT) begin
                     state       <= HALT;
                     halted      <= 1'b1;
                     instr_count <= instr_count + CNT_W'(1);
                  end else begin
                     state  <= UPDATE;
                     ld_pc  <= 1'b1;
                     pc_src <= takeJump(irOp, acc);
                  end
               end
            end
            UPDATE: begin
               instr_count <= instr_count + CNT_W'(1);
               state       <= FETCH;
            end
            HALT: halted <= 1'b1;
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Bench for the multi-cycle control unit: two instances (MEM_WAIT=0 and 2) driving a small
// accumulator datapath model, with a strobe scoreboard checked by an independent monitor.
module tb_unidade_controle_multiciclo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] rstV = 2'b00;
   logic       runA = 1'b0;
   logic       modelA = 1'b1;
   logic [3:0] opDrv = 4'h0;
   logic [7:0] accDrv = 8'h00;

   logic [1:0] dpRstW, ldAcW, acSrcW, ldPcW, pcSrcW, dmWeW, haltedW;
   logic [7:0] cntA, cntB;
   logic [2:0] dbgA, dbgB;
   logic [3:0] opA, opB;
   logic [7:0] accA, accB;

   // Datapath model: PC, data memory and accumulator, one copy per instance.
   logic [7:0] pcM [2];
   logic [7:0] accM [2];
   logic [7:0] dmem [2][16];
   logic [7:0] instM [2];

   int cycA = 0, cycB = 0;
   int nChecks = 0, nFail = 0;
   int ldPcCntA = 0;
   int base;

   logic [12:0] expQA[$];
   logic [12:0] expQB[$];

   function automatic logic [7:0] prog(input logic [7:0] addr);
      case (addr)
         8'd0: return 8'h15;
         8'd1: return 8'h36;
         8'd2: return 8'h27;
         8'd3: return 8'hF0;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] ula(input logic [3:0] op, input logic [7:0] a, input logic [7:0] m);
      case (op)
         4'h3: return a + m;
         4'h4: return a - m;
         4'h5: return a & m;
         4'h6: return a | m;
         4'h7: return a ^ m;
         default: return a;
      endcase
   endfunction

   assign instM[0] = prog(pcM[0]);
   assign instM[1] = prog(pcM[1]);
   assign opA  = modelA ? instM[0][7:4] : opDrv;
   assign accA = modelA ? accM[0] : accDrv;
   assign opB  = instM[1][7:4];
   assign accB = accM[1];

   unidade_controle_multiciclo #(.MEM_WAIT(0), .CNT_W(8)) dutA (
      .clock(clk), .reset(rstV[0]), .run(runA), .opcode(opA), .acc(accA),
      .dp_reset(dpRstW[0]), .ld_ac(ldAcW[0]), .ac_src(acSrcW[0]), .ld_pc(ldPcW[0]),
      .pc_src(pcSrcW[0]), .dm_we(dmWeW[0]), .halted(haltedW[0]), .instr_count(cntA),
      .dbgState(dbgA)
   );

   unidade_controle_multiciclo #(.MEM_WAIT(2), .CNT_W(8)) dutB (
      .clock(clk), .reset(rstV[1]), .run(1'b1), .opcode(opB), .acc(accB),
      .dp_reset(dpRstW[1]), .ld_ac(ldAcW[1]), .ac_src(acSrcW[1]), .ld_pc(ldPcW[1]),
      .pc_src(pcSrcW[1]), .dm_we(dmWeW[1]), .halted(haltedW[1]), .instr_count(cntB),
      .dbgState(dbgB)
   );

   always @(posedge clk) begin
      cycA <= rstV[0] ? cycA + 1 : 0;
      cycB <= rstV[1] ? cycB + 1 : 0;
      for (int i = 0; i < 2; i++) begin
         if (!rstV[i]) begin
            pcM[i]      <= 8'h00;
            accM[i]     <= 8'h00;
            dmem[i][5]  <= 8'h03;
            dmem[i][6]  <= 8'h04;
            dmem[i][7]  <= 8'h00;
         end else begin
            if (dpRstW[i])
               pcM[i] <= 8'h00;
            else if (ldPcW[i])
               pcM[i] <= pcSrcW[i] ? {4'h0, instM[i][3:0]} : pcM[i] + 8'd1;
            if (ldAcW[i])
               accM[i] <= acSrcW[i] ? dmem[i][instM[i][3:0]]
                                    : ula(instM[i][7:4], accM[i], dmem[i][instM[i][3:0]]);
            if (dmWeW[i])
               dmem[i][instM[i][3:0]] <= accM[i];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every strobe pulse must match the head of the expected queue ({cycle, ld_ac, ac_src, dm_we, ld_pc, pc_src}).
   always @(negedge clk) begin
      int n;
      if (ldAcW[0] | dmWeW[0] | ldPcW[0]) begin
         n = int'(ldAcW[0]) + int'(dmWeW[0]) + int'(ldPcW[0]);
         check("oneStrobeA", n, 1);
         if (ldPcW[0]) ldPcCntA++;
         if (expQA.size() == 0) begin
            nChecks++;
            nFail++;
            $display("FAIL unexpectedStrobeA: got %0h at cycle %0d expected none",
                     {ldAcW[0], acSrcW[0], dmWeW[0], ldPcW[0], pcSrcW[0]}, cycA);
         end else
            check("strobeA", {cycA[7:0], ldAcW[0], acSrcW[0], dmWeW[0], ldPcW[0], pcSrcW[0]},
                  expQA.pop_front());
      end
      if (ldAcW[1] | dmWeW[1] | ldPcW[1]) begin
         n = int'(ldAcW[1]) + int'(dmWeW[1]) + int'(ldPcW[1]);
         check("oneStrobeB", n, 1);
         if (expQB.size() == 0) begin
            nChecks++;
            nFail++;
            $display("FAIL unexpectedStrobeB: got %0h at cycle %0d expected none",
                     {ldAcW[1], acSrcW[1], dmWeW[1], ldPcW[1], pcSrcW[1]}, cycB);
         end else
            check("strobeB", {cycB[7:0], ldAcW[1], acSrcW[1], dmWeW[1], ldPcW[1], pcSrcW[1]},
                  expQB.pop_front());
      end
   end

   task automatic waitCycA(input int n);
      int guard = 0;
      while (cycA < n && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (cycA != n) check("waitCycA", cycA, n);
   endtask

   task automatic waitCycB(input int n);
      int guard = 0;
      while (cycB < n && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (cycB != n) check("waitCycB", cycB, n);
   endtask

   task automatic resetA();
      @(negedge clk);
      rstV[0] = 1'b0;
      repeat (2) @(negedge clk);
      check("rstDpResetA", dpRstW[0], 1);
      check("rstStrobesA", {ldAcW[0], acSrcW[0], dmWeW[0], ldPcW[0], pcSrcW[0], haltedW[0]}, 0);
      check("rstCountA", cntA, 0);
   endtask

   initial begin
      // Program 15 36 27 F0 on both instances.
      modelA = 1'b1;
      runA   = 1'b1;
      rstV   = 2'b00;
      repeat (2) @(negedge clk);
      check("rstDpResetA", dpRstW[0], 1);
      check("rstStrobesA", {ldAcW[0], acSrcW[0], dmWeW[0], ldPcW[0], pcSrcW[0], haltedW[0]}, 0);
      check("rstCountA", cntA, 0);
      check("rstHaltedB", haltedW[1], 0);
      expQA = '{{8'd2, 5'b11000}, {8'd3, 5'b00010}, {8'd5, 5'b10000},
                {8'd6, 5'b00010}, {8'd8, 5'b00100}, {8'd9, 5'b00010}};
      expQB = '{{8'd6, 5'b11000}, {8'd7, 5'b00010}, {8'd13, 5'b10000},
                {8'd14, 5'b00010}, {8'd18, 5'b00100}, {8'd19, 5'b00010}};
      base = ldPcCntA;
      rstV = 2'b11;
      @(negedge clk);
      check("initDpResetA", dpRstW[0], 0);
      begin
         int guard = 0;
         while (haltedW != 2'b11 && guard < 100) begin
            @(negedge clk);
            guard++;
         end
      end
      check("haltCycleB", cycB, 24);
      check("progHaltedA", haltedW[0], 1);
      check("progAccA", accM[0], 8'h07);
      check("progMem7A", dmem[0][7], 8'h07);
      check("progCountA", cntA, 4);
      check("progLdPcA", ldPcCntA - base, 3);
      check("progHaltedB", haltedW[1], 1);
      check("progAccB", accM[1], 8'h07);
      check("progMem7B", dmem[1][7], 8'h07);
      check("progCountB", cntB, 4);
      check("queueA1", expQA.size(), 0);
      check("queueB1", expQB.size(), 0);

      // Conditional jumps with a directly driven accumulator.
      modelA = 1'b0;
      opDrv  = 4'hA;
      accDrv = 8'h00;
      resetA();
      expQA = '{{8'd3, 5'b00011}, {8'd6, 5'b00010}, {8'd9, 5'b00011}, {8'd12, 5'b00010}};
      rstV[0] = 1'b1;
      waitCycA(4);  accDrv = 8'h01;
      waitCycA(7);  opDrv = 4'hB;
      waitCycA(10); accDrv = 8'h00;
      waitCycA(13); opDrv = 4'hF;
      waitCycA(16);
      check("jmpHaltedA", haltedW[0], 1);
      check("jmpCountA", cntA, 5);
      runA  = 1'b0;
      opDrv = 4'h1;
      waitCycA(20);
      check("haltStickyA", haltedW[0], 1);
      check("haltCountA", cntA, 5);
      check("queueA2", expQA.size(), 0);

      // Run/pause: FETCH holds with run low, resumes the cycle after run rises.
      runA  = 1'b0;
      opDrv = 4'h0;
      resetA();
      expQA = '{{8'd12, 5'b00010}};
      rstV[0] = 1'b1;
      waitCycA(10);
      check("pauseCountA", cntA, 0);
      check("pauseStateA", dbgA, 3'd1);
      runA = 1'b1;
      waitCycA(13);
      runA = 1'b0;
      waitCycA(14);
      check("resumeCountA", cntA, 1);
      check("queueA3", expQA.size(), 0);

      // Reset during EXEC of ADD on the MEM_WAIT=2 instance aborts the ld_ac pulse.
      @(negedge clk);
      rstV[1] = 1'b0;
      repeat (2) @(negedge clk);
      expQB = '{{8'd6, 5'b11000}, {8'd7, 5'b00010}};
      rstV[1] = 1'b1;
      waitCycB(12);
      check("abortPreCountB", cntB, 1);
      rstV[1] = 1'b0;
      @(negedge clk);
      check("abortDpResetB", dpRstW[1], 1);
      check("abortLdAcB", ldAcW[1], 0);
      check("abortCountB", cntB, 0);
      check("abortStateB", dbgB, 3'd0);
      check("queueB4", expQB.size(), 0);

      // 256 instructions of opcode C (NOP) wrap the counter.
      opDrv = 4'hC;
      runA  = 1'b1;
      resetA();
      for (int k = 1; k <= 256; k++) expQA.push_back({8'(3 * k), 5'b00010});
      rstV[0] = 1'b1;
      waitCycA(766);
      check("wrapPreA", cntA, 255);
      waitCycA(769);
      check("wrapA", cntA, 0);
      runA = 1'b0;
      waitCycA(772);
      check("queueA5", expQA.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
